dma_io_periph: RTL and testbench

DMA_IO_PERIPH -- requirements
Module: dma_io_periph

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_sync_fifo.sv | 61 ++++++
 rtl/dma_io_periph.sv | 168 ++++++++++++++++
 tb/tb_dma_io_periph.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and default sizing for the 8237 I/O peripheral
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_TERM
    } periph_state_e;

    localparam int DMA_DEPTH_DEFAULT  = 8;
    localparam int DMA_THRESH_DEFAULT = 4;

endpackage

// File: rtl/dma_sync_fifo.sv
// rtl/dma_sync_fifo.sv - single-clock FIFO with simultaneous push/pop and exact occupancy
module dma_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dma_io_periph.sv
// rtl/dma_io_periph.sv - 8237 single-channel I/O peripheral with buffering FIFO
module dma_io_periph
    import dma_pkg::*;
#(
    parameter int DEPTH  = DMA_DEPTH_DEFAULT,
    parameter int THRESH = DMA_THRESH_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    output logic                     DREQ,
    input  logic                     DACK,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic [7:0]               DB_IN,
    output logic [7:0]               DB_OUT,
    output logic                     DB_OE,
    input  logic                     EOP_N_IN,
    output logic                     EOP_N_OE,
    input  logic                     ENABLE,
    input  logic                     DIR,
    input  logic [7:0]               WR_DATA,
    input  logic                     WR_VALID,
    output logic                     WR_READY,
    output logic [7:0]               RD_DATA,
    output logic                     RD_VALID,
    input  logic                     RD_READY,
    input  logic                     FLUSH,
    output logic                     DONE,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_CNT = (AW+1)'(THRESH);
    localparam logic [AW:0] ONE_CNT    = (AW+1)'(1);

    periph_state_e state_q, state_d;
    logic       dir_q, dir_d, dreq_q, dreq_d, db_oe_q, db_oe_d;
    logic       eop_oe_q, eop_oe_d, done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
    logic       flush_q, flush_d, ior_n_q, ior_n_d, iow_n_q, iow_n_d, dack_q, dack_d;
    logic [7:0] db_out_q, db_out_d, db_in_q, db_in_d;

    logic [7:0]  fifo_head;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]  fifo_wdata;
    logic        dir_eff, ior_rise, iow_rise, dma_pop, dma_push, loc_push, loc_pop;
    logic        trigger, eop_req, flush_end, stop_xfer, ovf_ev, unf_ev;

    dma_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk       (CLK),
        .resetn    (RESET_N),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Direction follows the pin only while idle; mid-transfer changes wait for IDLE.
    assign dir_eff  = (state_q == ST_IDLE) ? DIR : dir_q;
    assign ior_rise = !ior_n_q && IOR_N;
    assign iow_rise = !iow_n_q && IOW_N;

    assign WR_READY = !dir_eff && (fifo_count < DEPTH_CNT);
    assign RD_VALID = dir_eff && !fifo_empty;
    assign loc_push = WR_VALID && WR_READY;
    assign loc_pop  = RD_VALID && RD_READY;

    assign dma_pop  = DACK && ior_rise && !dir_eff && !fifo_empty;
    assign unf_ev   = DACK && ior_rise && !dir_eff && fifo_empty;
    assign dma_push = DACK && iow_rise && dir_eff;
    assign ovf_ev   = dma_push && fifo_full && !loc_pop;

    assign fifo_push  = loc_push || dma_push;
    assign fifo_pop   = loc_pop || dma_pop;
    assign fifo_wdata = dir_eff ? db_in_q : WR_DATA;

    assign trigger   = dir_eff ? ((DEPTH_CNT - fifo_count) >= THRESH_CNT)
                               : ((fifo_count >= THRESH_CNT) || (flush_q && !fifo_empty));
    assign eop_req   = DACK && !EOP_N_IN;
    assign flush_end = flush_q && dma_pop && (fifo_count == ONE_CNT) && !loc_push;
    assign stop_xfer = dir_eff ? fifo_full : fifo_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ENABLE && trigger) state_d = ST_REQ;
            ST_REQ: begin
                if (eop_req || flush_end) state_d = ST_TERM;
                else if (!ENABLE)         state_d = ST_IDLE;
                else if (DACK)            state_d = ST_XFER;
            end
            ST_XFER: begin
                if (eop_req || flush_end) state_d = ST_TERM;
                else if (dack_q && !DACK) state_d = trigger ? ST_REQ : ST_IDLE;
            end
            ST_TERM: if (!ENABLE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        dir_d    = dir_eff;
        dreq_d   = (state_d == ST_REQ) || ((state_d == ST_XFER) && !stop_xfer);
        db_oe_d  = DACK && !IOR_N && !dir_eff;
        db_out_d = db_oe_d ? (fifo_empty ? 8'hFF : fifo_head) : 8'h00;
        eop_oe_d = db_oe_d && flush_q && (fifo_count == ONE_CNT);
        done_d   = (state_d == ST_TERM) && (state_q != ST_TERM);
        ovf_d    = ovf_q || ovf_ev;
        unf_d    = unf_q || unf_ev;
        flush_d  = flush_q;
        if (state_q == ST_TERM)       flush_d = 1'b0;
        else if (FLUSH && !dir_eff)   flush_d = 1'b1;
        ior_n_d  = IOR_N;
        iow_n_d  = IOW_N;
        dack_d   = DACK;
        db_in_d  = !IOW_N ? DB_IN : db_in_q;
    end

    // Strobe history resets high so a strobe already low at reset never completes.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            dreq_q   <= 1'b0;
            db_oe_q  <= 1'b0;
            db_out_q <= 8'h00;
            eop_oe_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            flush_q  <= 1'b0;
            ior_n_q  <= 1'b1;
            iow_n_q  <= 1'b1;
            dack_q   <= 1'b0;
            db_in_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            dreq_q   <= dreq_d;
            db_oe_q  <= db_oe_d;
            db_out_q <= db_out_d;
            eop_oe_q <= eop_oe_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            flush_q  <= flush_d;
            ior_n_q  <= ior_n_d;
            iow_n_q  <= iow_n_d;
            dack_q   <= dack_d;
            db_in_q  <= db_in_d;
        end
    end

    assign DREQ     = dreq_q;
    assign DB_OE    = db_oe_q;
    assign DB_OUT   = db_out_q;
    assign EOP_N_OE = eop_oe_q;
    assign DONE     = done_q;
    assign OVF      = ovf_q;
    assign UNF      = unf_q;
    assign COUNT    = fifo_count;
    assign RD_DATA  = fifo_head;

endmodule

// File: tb/tb_dma_io_periph.sv
// tb/tb_dma_io_periph.sv - scoreboard bench for dma_io_periph
module tb_dma_io_periph;

    logic       CLK, RESET_N, DREQ, DACK, IOR_N, IOW_N, DB_OE, EOP_N_IN, EOP_N_OE;
    logic       ENABLE, DIR, WR_VALID, WR_READY, RD_VALID, RD_READY, FLUSH, DONE, OVF, UNF;
    logic [7:0] DB_IN, DB_OUT, WR_DATA, RD_DATA;
    logic [3:0] COUNT;

    logic [7:0] exp_q[$];
    int         checks, failures;
    logic       oe_prev, eop_seen;

    dma_io_periph #(.DEPTH(8), .THRESH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .EOP_N_IN(EOP_N_IN), .EOP_N_OE(EOP_N_OE), .ENABLE(ENABLE), .DIR(DIR),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .FLUSH(FLUSH), .DONE(DONE), .COUNT(COUNT), .OVF(OVF), .UNF(UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_pop(input string name, input logic [7:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected output actual=%0h required=none", name, act);
        end else begin
            check(name, {24'h0, act}, {24'h0, exp_q.pop_front()});
        end
    endtask

    // Monitor: one DB_OUT sample per IOR strobe, one RD_DATA sample per handshake.
    initial begin
        oe_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET_N && DB_OE && !oe_prev) compare_pop("db_out", DB_OUT);
            if (RESET_N && RD_VALID && RD_READY) compare_pop("rd_data", RD_DATA);
            oe_prev = DB_OE;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_local(input logic [7:0] b, input bit track);
        WR_DATA = b;
        WR_VALID = 1'b1;
        if (track) exp_q.push_back(b);
        tick(1);
        WR_VALID = 1'b0;
    endtask

    task automatic ior_pulse(output logic eop);
        IOR_N = 1'b0;
        tick(1);
        eop = EOP_N_OE;
        tick(1);
        IOR_N = 1'b1;
        tick(1);
    endtask

    task automatic iow_pulse(input logic [7:0] b, input bit track);
        DB_IN = b;
        IOW_N = 1'b0;
        if (track) exp_q.push_back(b);
        tick(2);
        IOW_N = 1'b1;
        tick(1);
    endtask

    task automatic drain_rd(input int n);
        RD_READY = 1'b1;
        tick(n);
        RD_READY = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dreq"}, {31'h0, DREQ}, 0);
        check({tag, "_db_oe"}, {31'h0, DB_OE}, 0);
        check({tag, "_db_out"}, {24'h0, DB_OUT}, 0);
        check({tag, "_eop_oe"}, {31'h0, EOP_N_OE}, 0);
        check({tag, "_done"}, {31'h0, DONE}, 0);
        check({tag, "_ovf"}, {31'h0, OVF}, 0);
        check({tag, "_unf"}, {31'h0, UNF}, 0);
        check({tag, "_count"}, {28'h0, COUNT}, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; DB_IN = 8'h00;
        EOP_N_IN = 1'b1; ENABLE = 1'b0; DIR = 1'b0; WR_DATA = 8'h00; WR_VALID = 1'b0;
        RD_READY = 1'b0; FLUSH = 1'b0;
        tick(3);
        check_reset_vals("rst");
        RESET_N = 1'b1;
        tick(1);

        // Device->memory: threshold request and four DMA reads
        ENABLE = 1'b1;
        push_local(8'h11, 1); push_local(8'h22, 1); push_local(8'h33, 1); push_local(8'h44, 1);
        check("dreq_before", {31'h0, DREQ}, 0);
        check("count_4", {28'h0, COUNT}, 4);
        tick(1);
        check("dreq_rise", {31'h0, DREQ}, 1);
        DACK = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) ior_pulse(eop_seen);
        tick(1);
        check("dreq_after_empty", {31'h0, DREQ}, 0);
        check("count_0", {28'h0, COUNT}, 0);
        DACK = 1'b0;
        tick(2);

        // Flush of a partial FIFO
        push_local(8'h55, 1); push_local(8'h66, 1);
        tick(1);
        check("dreq_below_thresh", {31'h0, DREQ}, 0);
        FLUSH = 1'b1; tick(1); FLUSH = 1'b0; tick(1);
        check("flush_dreq", {31'h0, DREQ}, 1);
        DACK = 1'b1;
        tick(1);
        ior_pulse(eop_seen);
        check("eop_first", {31'h0, eop_seen}, 0);
        ior_pulse(eop_seen);
        check("eop_last", {31'h0, eop_seen}, 1);
        check("flush_done", {31'h0, DONE}, 1);
        check("flush_dreq_low", {31'h0, DREQ}, 0);
        tick(1);
        check("flush_done_pulse", {31'h0, DONE}, 0);
        check("flush_eop_release", {31'h0, EOP_N_OE}, 0);
        tick(2);
        check("term_hold", {31'h0, DREQ}, 0);
        ENABLE = 1'b0; DACK = 1'b0;
        tick(1);

        // External EOP mid-transfer
        ENABLE = 1'b1;
        push_local(8'h77, 1); push_local(8'h88, 1); push_local(8'h99, 1); push_local(8'hAA, 1);
        tick(1);
        DACK = 1'b1;
        tick(1);
        ior_pulse(eop_seen);
        check("eop_pre_count", {28'h0, COUNT}, 3);
        EOP_N_IN = 1'b0;
        tick(1);
        check("eop_done", {31'h0, DONE}, 1);
        check("eop_dreq", {31'h0, DREQ}, 0);
        check("eop_count", {28'h0, COUNT}, 3);
        EOP_N_IN = 1'b1;
        tick(1);
        check("eop_done_pulse", {31'h0, DONE}, 0);
        ENABLE = 1'b0; DACK = 1'b0;
        tick(1);
        DACK = 1'b1;
        for (int i = 0; i < 3; i++) ior_pulse(eop_seen);
        DACK = 1'b0;
        check("eop_drained", {28'h0, COUNT}, 0);

        // Memory->device: DMA writes, local pops, overflow
        DIR = 1'b1;
        tick(1);
        check("wr_ready_dir1", {31'h0, WR_READY}, 0);
        DACK = 1'b1;
        for (int i = 0; i < 4; i++) iow_pulse(8'hA0 + 8'(i), 1);
        check("iow_count_4", {28'h0, COUNT}, 4);
        DACK = 1'b0;
        drain_rd(4);
        check("rd_drained", {28'h0, COUNT}, 0);
        DACK = 1'b1;
        for (int i = 0; i < 8; i++) iow_pulse(8'hB0 + 8'(i), 1);
        check("full_count", {28'h0, COUNT}, 8);
        check("ovf_before", {31'h0, OVF}, 0);
        iow_pulse(8'hC0, 0);
        check("ovf_set", {31'h0, OVF}, 1);
        check("ovf_count", {28'h0, COUNT}, 8);
        DACK = 1'b0;
        drain_rd(8);
        check("ovf_drained", {28'h0, COUNT}, 0);

        // Underflow read
        DIR = 1'b0;
        tick(1);
        check("unf_before", {31'h0, UNF}, 0);
        DACK = 1'b1;
        exp_q.push_back(8'hFF);
        ior_pulse(eop_seen);
        DACK = 1'b0;
        check("unf_set", {31'h0, UNF}, 1);
        check("unf_count", {28'h0, COUNT}, 0);

        // Reset during an active IOR strobe
        push_local(8'hD1, 1); push_local(8'hD2, 0);
        DACK = 1'b1;
        IOR_N = 1'b0;
        tick(2);
        check("oe_before_reset", {31'h0, DB_OE}, 1);
        RESET_N = 1'b0;
        tick(1);
        check_reset_vals("midrst");
        RESET_N = 1'b1;
        IOR_N = 1'b1;
        tick(2);
        check("no_pop_count", {28'h0, COUNT}, 0);
        check("no_pop_unf", {31'h0, UNF}, 0);
        DACK = 1'b0;
        push_local(8'hE5, 1);
        DACK = 1'b1;
        ior_pulse(eop_seen);
        DACK = 1'b0;
        check("post_rst_count", {28'h0, COUNT}, 0);
        check("post_rst_unf", {31'h0, UNF}, 0);

        tick(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
